// File: rtl/traffic_light_controller_param.sv
// -----------------------------------------------------------------------------
// traffic_light_controller_param
//
// Two-road traffic light sequencer with parametrised phase durations:
//   MAIN_G -> MAIN_Y -> RED_A -> SIDE_G -> SIDE_Y -> RED_B -> MAIN_G ...
// Main green is held until a latched side-road demand is present and the
// minimum main-green time has elapsed. A flash (night/maintenance) mode
// blinks main yellow / side red once the current green has cleared through
// its yellow and all-red.
//
// Optional feature macro: PED_REQ_EN
//   When defined, adds ped_req (sets the side demand like side_req) and
//   ped_walk (high exactly during SIDE_G).
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   side_req    in   side-road sensor, single-cycle pulse is enough
//   flash_mode  in   level, 1 requests flash mode
//   ped_req     in   (PED_REQ_EN only) pedestrian push button
//   light_main  out  main lamps {red,yellow,green}, registered
//   light_side  out  side lamps {red,yellow,green}, registered
//   phase       out  current state encoding, registered
//   ped_walk    out  (PED_REQ_EN only) walk lamp, registered
// -----------------------------------------------------------------------------
module traffic_light_controller_param #(
  parameter int GREEN_MAIN_CYC = 10,
  parameter int GREEN_SIDE_CYC = 6,
  parameter int YELLOW_CYC     = 3,
  parameter int ALL_RED_CYC    = 2,
  parameter int FLASH_CYC      = 4,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       side_req,
  input  logic       flash_mode,
`ifdef PED_REQ_EN
  input  logic       ped_req,
  output logic       ped_walk,
`endif
  output logic [2:0] light_main,
  output logic [2:0] light_side,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    RED_A  = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    RED_B  = 3'd5,
    FLASH  = 3'd6
  } state_t;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Counter load values: a state lasting DUR cycles starts at DUR-1.
  localparam logic [CNT_W-1:0] L_MAIN_G  = CNT_W'(GREEN_MAIN_CYC - 1);
  localparam logic [CNT_W-1:0] L_SIDE_G  = CNT_W'(GREEN_SIDE_CYC - 1);
  localparam logic [CNT_W-1:0] L_YELLOW  = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] L_ALL_RED = CNT_W'(ALL_RED_CYC - 1);
  localparam logic [CNT_W-1:0] L_FLASH   = CNT_W'(FLASH_CYC - 1);

  function automatic logic [CNT_W-1:0] load_val(input state_t s);
    case (s)
      MAIN_G:          return L_MAIN_G;
      SIDE_G:          return L_SIDE_G;
      MAIN_Y, SIDE_Y:  return L_YELLOW;
      FLASH:           return L_FLASH;
      default:         return L_ALL_RED;
    endcase
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic             r_blink;
  logic [2:0]       r_light_main;
  logic [2:0]       r_light_side;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_blink_nxt;
  logic             w_pending_nxt;
  logic [2:0]       w_main_nxt;
  logic [2:0]       w_side_nxt;
  logic             w_cnt_zero;
  logic             w_req;

  assign w_cnt_zero = (r_cnt == '0);

`ifdef PED_REQ_EN
  logic r_ped_walk;
  assign w_req    = side_req | ped_req;
  assign ped_walk = r_ped_walk;
`else
  assign w_req = side_req;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_blink_nxt = r_blink;

    case (r_state)
      MAIN_G: if ((w_cnt_zero && r_pending) || flash_mode) w_state_nxt = MAIN_Y;
      MAIN_Y: if (w_cnt_zero) w_state_nxt = RED_A;
      RED_A:  if (w_cnt_zero) w_state_nxt = flash_mode ? FLASH : SIDE_G;
      SIDE_G: if (w_cnt_zero || flash_mode) w_state_nxt = SIDE_Y;
      SIDE_Y: if (w_cnt_zero) w_state_nxt = RED_B;
      RED_B:  if (w_cnt_zero) w_state_nxt = flash_mode ? FLASH : MAIN_G;
      FLASH:  if (!flash_mode) w_state_nxt = RED_B;
      default: w_state_nxt = RED_B;   // unused encoding recovers to all-red
    endcase

    if (w_state_nxt != r_state) begin
      // Blink is only visible in FLASH; forcing it to 1 on every state
      // change guarantees FLASH always starts with the lamps lit.
      w_cnt_nxt   = load_val(w_state_nxt);
      w_blink_nxt = 1'b1;
    end else if (r_state == FLASH && w_cnt_zero) begin
      w_cnt_nxt   = L_FLASH;
      w_blink_nxt = ~r_blink;
    end else if (!w_cnt_zero) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end

    // A request coinciding with the edge into SIDE_G is served by that
    // side cycle, so the clear wins over the set.
    if (w_state_nxt == SIDE_G && r_state != SIDE_G) w_pending_nxt = 1'b0;
    else                                            w_pending_nxt = r_pending | w_req;

    // Lamps are decoded from the next state so they change on the same
    // edge as the state register.
    w_main_nxt = LAMP_R;
    w_side_nxt = LAMP_R;
    case (w_state_nxt)
      MAIN_G: w_main_nxt = LAMP_G;
      MAIN_Y: w_main_nxt = LAMP_Y;
      SIDE_G: w_side_nxt = LAMP_G;
      SIDE_Y: w_side_nxt = LAMP_Y;
      FLASH: begin
        w_main_nxt = w_blink_nxt ? LAMP_Y : LAMP_OFF;
        w_side_nxt = w_blink_nxt ? LAMP_R : LAMP_OFF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= RED_B;
      r_cnt        <= L_ALL_RED;
      r_pending    <= 1'b0;
      r_blink      <= 1'b1;
      r_light_main <= LAMP_R;
      r_light_side <= LAMP_R;
`ifdef PED_REQ_EN
      r_ped_walk   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // same pre-edge values regardless of statement order.
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pending    <= w_pending_nxt;
      r_blink      <= w_blink_nxt;
      r_light_main <= w_main_nxt;
      r_light_side <= w_side_nxt;
`ifdef PED_REQ_EN
      r_ped_walk   <= (w_state_nxt == SIDE_G);
`endif
    end
  end

  assign light_main = r_light_main;
  assign light_side = r_light_side;
  assign phase      = r_state;

endmodule

// File: tb/tb_traffic_light_controller_param.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_controller_param
//
// Directed, self-checking bench for traffic_light_controller_param with
// default parameters. Each scenario task builds the expected per-cycle lamp /
// phase sequence from the state table, drives its stimulus and compares at
// every falling edge. Build with +define+PED_REQ_EN to include the
// pedestrian scenario and the ped_walk checks.
// -----------------------------------------------------------------------------
module tb_traffic_light_controller_param;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       side_req   = 1'b0;
  logic       flash_mode = 1'b0;
  logic [2:0] light_main;
  logic [2:0] light_side;
  logic [2:0] phase;
`ifdef PED_REQ_EN
  logic       ped_req    = 1'b0;
  logic       ped_walk;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [2:0] S_MAIN_G = 3'd0;
  localparam logic [2:0] S_MAIN_Y = 3'd1;
  localparam logic [2:0] S_RED_A  = 3'd2;
  localparam logic [2:0] S_SIDE_G = 3'd3;
  localparam logic [2:0] S_SIDE_Y = 3'd4;
  localparam logic [2:0] S_RED_B  = 3'd5;
  localparam logic [2:0] S_FLASH  = 3'd6;

  typedef struct packed {
    logic [2:0] m;
    logic [2:0] s;
    logic [2:0] ph;
    logic       w;
  } obs_t;

  obs_t exp_q[$];

  traffic_light_controller_param dut (
    .clk        (clk),
    .reset      (reset),
    .side_req   (side_req),
    .flash_mode (flash_mode),
`ifdef PED_REQ_EN
    .ped_req    (ped_req),
    .ped_walk   (ped_walk),
`endif
    .light_main (light_main),
    .light_side (light_side),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  // Append n cycles of state st to the expected sequence.
  function automatic void add_seg(input logic [2:0] st, input int n, input logic blink);
    obs_t e;
    e.ph = st;
    e.m  = 3'b100;
    e.s  = 3'b100;
    case (st)
      S_MAIN_G: e.m = 3'b001;
      S_MAIN_Y: e.m = 3'b010;
      S_SIDE_G: e.s = 3'b001;
      S_SIDE_Y: e.s = 3'b010;
      S_FLASH: begin
        e.m = blink ? 3'b010 : 3'b000;
        e.s = blink ? 3'b100 : 3'b000;
      end
      default: ;
    endcase
`ifdef PED_REQ_EN
    e.w = (st == S_SIDE_G);
`else
    e.w = 1'b0;
`endif
    for (int k = 0; k < n; k++) exp_q.push_back(e);
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.m  = light_main;
    o.s  = light_side;
    o.ph = phase;
`ifdef PED_REQ_EN
    o.w  = ped_walk;
`else
    o.w  = 1'b0;
`endif
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("main=%b side=%b phase=%0d walk=%b", o.m, o.s, o.ph, o.w);
  endfunction

  // Reset held across one rising edge, released on a falling edge. The
  // release cycle is the first of the two all-red cycles.
  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b0;
    side_req   = 1'b0;
    flash_mode = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
  endtask

  // The standard side cycle following a demand latched in main green.
  function automatic void add_side_cycle();
    add_seg(S_MAIN_Y, 3, 1'b1);
    add_seg(S_RED_A,  2, 1'b1);
    add_seg(S_SIDE_G, 6, 1'b1);
    add_seg(S_SIDE_Y, 3, 1'b1);
    add_seg(S_RED_B,  2, 1'b1);
  endfunction

  task automatic test_reset();
    obs_t o;
    #2 reset = 1'b0;
    exp_q.delete();
    add_seg(S_RED_B, 2, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      o = observe();
      n_tests++;
      if (o !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %s, expected %s", i, fmt(o), fmt(exp_q[i]));
      end
    end
    reset = 1'b1;
    exp_q.delete();
    add_seg(S_RED_B, 1, 1'b1);
    add_seg(S_MAIN_G, 55, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      o = observe();
      n_tests++;
      if (o !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: got %s, expected %s", i, fmt(o), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_side_cycle();
    obs_t o;
    do_reset();
    add_seg(S_RED_B, 1, 1'b1);
    add_seg(S_MAIN_G, 10, 1'b1);
    add_side_cycle();
    add_seg(S_MAIN_G, 12, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      o = observe();
      n_tests++;
      if (o !== exp_q[i]) begin
        n_fail++;
        $display("FAIL side_cycle[%0d]: got %s, expected %s", i, fmt(o), fmt(exp_q[i]));
      end
      side_req = (i == 3);
    end
    side_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    obs_t o;
    do_reset();
    add_seg(S_RED_B, 1, 1'b1);
    add_seg(S_MAIN_G, 10, 1'b1);
    add_side_cycle();
    add_seg(S_MAIN_G, 10, 1'b1);
    add_side_cycle();
    add_seg(S_MAIN_G, 4, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      o = observe();
      n_tests++;
      if (o !== exp_q[i]) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %s, expected %s", i, fmt(o), fmt(exp_q[i]));
      end
      side_req = (i == 3) || (i == 17);   // index 17 is the 2nd SIDE_G cycle
    end
    side_req = 1'b0;
  endtask

  task automatic test_absorb();
    obs_t o;
    do_reset();
    add_seg(S_RED_B, 1, 1'b1);
    add_seg(S_MAIN_G, 10, 1'b1);
    add_side_cycle();
    add_seg(S_MAIN_G, 12, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      o = observe();
      n_tests++;
      if (o !== exp_q[i]) begin
        n_fail++;
        $display("FAIL absorb[%0d]: got %s, expected %s", i, fmt(o), fmt(exp_q[i]));
      end
      side_req = (i == 3) || (i == 15);   // index 15 is the last RED_A cycle
    end
    side_req = 1'b0;
  endtask

  task automatic test_flash();
    obs_t o;
    do_reset();
    add_seg(S_RED_B, 1, 1'b1);
    add_seg(S_MAIN_G, 4, 1'b1);
    add_seg(S_MAIN_Y, 3, 1'b1);
    add_seg(S_RED_A, 2, 1'b1);
    add_seg(S_FLASH, 4, 1'b1);
    add_seg(S_FLASH, 4, 1'b0);
    add_seg(S_FLASH, 4, 1'b1);
    add_seg(S_FLASH, 4, 1'b0);
    add_seg(S_RED_B, 2, 1'b1);
    add_seg(S_MAIN_G, 5, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      o = observe();
      n_tests++;
      if (o !== exp_q[i]) begin
        n_fail++;
        $display("FAIL flash_main[%0d]: got %s, expected %s", i, fmt(o), fmt(exp_q[i]));
      end
      flash_mode = (i >= 4) && (i < 25);
    end
    flash_mode = 1'b0;
  endtask

  task automatic test_flash_side();
    obs_t o;
    do_reset();
    add_seg(S_RED_B, 1, 1'b1);
    add_seg(S_MAIN_G, 10, 1'b1);
    add_seg(S_MAIN_Y, 3, 1'b1);
    add_seg(S_RED_A, 2, 1'b1);
    add_seg(S_SIDE_G, 2, 1'b1);
    add_seg(S_SIDE_Y, 3, 1'b1);
    add_seg(S_RED_B, 2, 1'b1);
    add_seg(S_FLASH, 4, 1'b1);
    add_seg(S_FLASH, 4, 1'b0);
    add_seg(S_RED_B, 2, 1'b1);
    add_seg(S_MAIN_G, 5, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      o = observe();
      n_tests++;
      if (o !== exp_q[i]) begin
        n_fail++;
        $display("FAIL flash_side[%0d]: got %s, expected %s", i, fmt(o), fmt(exp_q[i]));
      end
      side_req   = (i == 3);
      flash_mode = (i >= 17) && (i < 30);
    end
    side_req   = 1'b0;
    flash_mode = 1'b0;
  endtask

  task automatic test_async_reset();
    obs_t o;
    obs_t e_rst;
    do_reset();
    add_seg(S_RED_B, 1, 1'b1);
    add_seg(S_MAIN_G, 10, 1'b1);
    add_seg(S_MAIN_Y, 3, 1'b1);
    add_seg(S_RED_A, 2, 1'b1);
    add_seg(S_SIDE_G, 3, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      o = observe();
      n_tests++;
      if (o !== exp_q[i]) begin
        n_fail++;
        $display("FAIL async_pre[%0d]: got %s, expected %s", i, fmt(o), fmt(exp_q[i]));
      end
      side_req = (i == 3) || (i == 17);   // the SIDE_G pulse must be lost by reset
    end
    side_req = 1'b0;
    // Assert reset between edges; outputs must go all-red before the next edge.
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    add_seg(S_RED_B, 1, 1'b1);
    e_rst = exp_q[0];
    o = observe();
    n_tests++;
    if (o !== e_rst) begin
      n_fail++;
      $display("FAIL async_assert: got %s, expected %s", fmt(o), fmt(e_rst));
    end
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    add_seg(S_RED_B, 1, 1'b1);
    add_seg(S_MAIN_G, 12, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      o = observe();
      n_tests++;
      if (o !== exp_q[i]) begin
        n_fail++;
        $display("FAIL async_post[%0d]: got %s, expected %s", i, fmt(o), fmt(exp_q[i]));
      end
    end
  endtask

`ifdef PED_REQ_EN
  task automatic test_ped();
    obs_t o;
    do_reset();
    add_seg(S_RED_B, 1, 1'b1);
    add_seg(S_MAIN_G, 10, 1'b1);
    add_side_cycle();
    add_seg(S_MAIN_G, 6, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      o = observe();
      n_tests++;
      if (o !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ped[%0d]: got %s, expected %s", i, fmt(o), fmt(exp_q[i]));
      end
      ped_req = (i == 3);
    end
    ped_req = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_side_cycle();
    test_back_to_back();
    test_absorb();
    test_flash();
    test_flash_side();
    test_async_reset();
`ifdef PED_REQ_EN
    test_ped();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
